pwm_multi_ip: RTL and testbench

PWM_MULTI_IP -- requirements
Module: pwm_multi_ip

---
 rtl/pwm_pkg.sv | 34 +++
 rtl/pwm_multi_ip_if.sv | 11 +
 rtl/pwm_chan.sv | 49 ++++
 rtl/pwm_multi_ip.sv | 171 +++++++++++++++++
 tb/tb_pwm_multi_ip.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map, bit indices and mode encodings for pwm_multi_ip
package pwm_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_PERIOD = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_CHCFG  = 8'h0C;
  localparam logic [7:0] ADDR_DUTY0  = 8'h10;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  localparam int STAT_RUN_BIT  = 0;
  localparam int STAT_PEF_BIT  = 1;
  localparam int STAT_CNT_LSB  = 16;
  localparam int CHCFG_POL_LSB = 16;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  // Byte offset of the duty register of channel n
  function automatic logic [7:0] duty_addr(input int n);
    return ADDR_DUTY0 + 8'(4 * n);
  endfunction

endpackage

// File: rtl/pwm_multi_ip_if.sv
// rtl/pwm_multi_ip_if.sv - register bus bundle for pwm_multi_ip
interface pwm_multi_ip_if;
  logic        i_sel;
  logic        i_we;
  logic [7:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;

  modport master (output i_sel, output i_we, output i_addr, output i_wdata, input o_rdata);
  modport slave  (input i_sel, input i_we, input i_addr, input i_wdata, output o_rdata);
endinterface

// File: rtl/pwm_chan.sv
// rtl/pwm_chan.sv - one PWM channel: duty shadow/active, compare, polarity, output flop
module pwm_chan #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             duty_we_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             run_i,
  input  logic             pol_i,
  output logic [CNT_W-1:0] duty_sh_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [CNT_W-1:0] duty_act_q, duty_act_d;
  logic [CNT_W-1:0] limit;
  logic             active;
  logic             pwm_q, pwm_d;

  // Compare against min(duty, period) so an oversized duty means always active
  always_comb begin
    duty_sh_d  = duty_we_i ? wdata_i : duty_sh_q;
    duty_act_d = load_i ? duty_sh_q : duty_act_q;
    limit      = (duty_act_q < period_i) ? duty_act_q : period_i;
    active     = (cnt_i < limit);
    pwm_d      = (run_i & active) ^ pol_i;
  end

  // Duty registers and the registered output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pwm_q      <= pwm_d;
    end
  end

  assign duty_sh_o = duty_sh_q;
  assign pwm_o     = pwm_q;

endmodule

// File: rtl/pwm_multi_ip.sv
// rtl/pwm_multi_ip.sv - multi-channel PWM: bus decode, shared counter, boundary and PEF
module pwm_multi_ip #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  pwm_multi_ip_if.slave     bus,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              o_irq
);
  import pwm_pkg::*;

  logic wr, rd;
  logic wr_ctrl, wr_period, w1c_pef;
  logic [NUM_CH-1:0] wr_duty;

  logic en_q, en_d, irq_en_q, irq_en_d;
  pwm_mode_e mode_q, mode_d;
  logic [NUM_CH-1:0] ch_en_q, ch_en_d, ch_pol_q, ch_pol_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d, period_act_q, period_act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, p_last;
  pwm_dir_e dir_q, dir_d;
  logic pef_q, pef_d;
  logic bnd, restart, load;
  logic [CNT_W-1:0] duty_sh [NUM_CH];
  logic [31:0] rdata, cnt_ext;
  logic unused_bits;

  assign wr        = bus.i_sel & bus.i_we;
  assign rd        = bus.i_sel & ~bus.i_we;
  assign wr_ctrl   = wr && (bus.i_addr == ADDR_CTRL);
  assign wr_period = wr && (bus.i_addr == ADDR_PERIOD);
  assign w1c_pef   = wr && (bus.i_addr == ADDR_STATUS) && bus.i_wdata[STAT_PEF_BIT];
  assign p_last    = period_act_q - CNT_W'(1);
  assign cnt_ext   = 32'(cnt_q);
  assign unused_bits = ^{bus.i_wdata, cnt_ext};

  // Register writes; PERIOD of zero is stored as one
  always_comb begin
    en_d        = en_q;
    mode_d      = mode_q;
    irq_en_d    = irq_en_q;
    ch_en_d     = ch_en_q;
    ch_pol_d    = ch_pol_q;
    period_sh_d = period_sh_q;
    if (wr_ctrl) begin
      en_d     = bus.i_wdata[CTRL_EN_BIT];
      mode_d   = pwm_mode_e'(bus.i_wdata[CTRL_MODE_BIT]);
      irq_en_d = bus.i_wdata[CTRL_IRQEN_BIT];
    end
    if (wr && (bus.i_addr == ADDR_CHCFG)) begin
      ch_en_d  = bus.i_wdata[NUM_CH-1:0];
      ch_pol_d = bus.i_wdata[CHCFG_POL_LSB +: NUM_CH];
    end
    if (wr_period) begin
      if (bus.i_wdata[CNT_W-1:0] == '0) period_sh_d = CNT_W'(1);
      else                              period_sh_d = bus.i_wdata[CNT_W-1:0];
    end
  end

  // Boundary: edge wrap cycle, or the down-to-up flip at zero in center mode
  always_comb begin
    bnd = 1'b0;
    if (en_q) begin
      if (mode_q == MODE_EDGE) bnd = (cnt_q >= p_last);
      else                     bnd = (dir_q == DIR_DOWN) && (cnt_q == '0);
    end
  end

  assign restart = wr_ctrl && en_d && (!en_q || (mode_d != mode_q));
  assign load    = bnd || restart;

  // Counter and direction stepping; idle or restart parks at zero counting up
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!en_d || restart) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_q == MODE_EDGE) begin
      dir_d = DIR_UP;
      cnt_d = bnd ? '0 : cnt_q + CNT_W'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= p_last) dir_d = DIR_DOWN;
      else                 cnt_d = cnt_q + CNT_W'(1);
    end else begin
      if (cnt_q == '0) dir_d = DIR_UP;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
    period_act_d = load ? period_sh_q : period_act_q;
    pef_d = bnd ? 1'b1 : (w1c_pef ? 1'b0 : pef_q);
  end

  // Control and counter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q         <= 1'b0;
      mode_q       <= MODE_EDGE;
      irq_en_q     <= 1'b0;
      ch_en_q      <= '0;
      ch_pol_q     <= '0;
      period_sh_q  <= CNT_W'(1);
      period_act_q <= CNT_W'(1);
      cnt_q        <= '0;
      dir_q        <= DIR_UP;
      pef_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      mode_q       <= mode_d;
      irq_en_q     <= irq_en_d;
      ch_en_q      <= ch_en_d;
      ch_pol_q     <= ch_pol_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pef_q        <= pef_d;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign wr_duty[n] = wr && (bus.i_addr == duty_addr(n));
    pwm_chan #(.CNT_W(CNT_W)) u_chan (
      .clk       (clk),
      .reset     (reset),
      .duty_we_i (wr_duty[n]),
      .wdata_i   (bus.i_wdata[CNT_W-1:0]),
      .load_i    (load),
      .cnt_i     (cnt_q),
      .period_i  (period_act_q),
      .run_i     (en_q & ch_en_q[n]),
      .pol_i     (ch_pol_q[n]),
      .duty_sh_o (duty_sh[n]),
      .pwm_o     (pwm_out[n])
    );
  end

  // Read mux; zero when idle, writing or unmapped
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (bus.i_addr)
        ADDR_CTRL: begin
          rdata[CTRL_EN_BIT]    = en_q;
          rdata[CTRL_MODE_BIT]  = (mode_q == MODE_CENTER);
          rdata[CTRL_IRQEN_BIT] = irq_en_q;
        end
        ADDR_PERIOD: rdata = 32'(period_sh_q);
        ADDR_STATUS: begin
          rdata[STAT_RUN_BIT]        = en_q;
          rdata[STAT_PEF_BIT]        = pef_q;
          rdata[STAT_CNT_LSB +: 16]  = cnt_ext[15:0];
        end
        ADDR_CHCFG: begin
          rdata[NUM_CH-1:0]               = ch_en_q;
          rdata[CHCFG_POL_LSB +: NUM_CH]  = ch_pol_q;
        end
        default: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (bus.i_addr == duty_addr(n)) rdata = 32'(duty_sh[n]);
          end
        end
      endcase
    end
  end

  assign bus.o_rdata = rdata;
  assign o_irq       = pef_q & irq_en_q;

endmodule

// File: tb/tb_pwm_multi_ip.sv
// tb/tb_pwm_multi_ip.sv - directed self-checking bench for pwm_multi_ip
module tb_pwm_multi_ip;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pwm_out;
  logic       o_irq;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  pwm_multi_ip_if bus_if ();

  pwm_multi_ip #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .pwm_out (pwm_out),
    .o_irq   (o_irq)
  );

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus_if.i_sel   = 1'b0;
    bus_if.i_we    = 1'b0;
    bus_if.i_addr  = 8'h00;
    bus_if.i_wdata = 32'h0;
  endtask

  task automatic drive_wr(input logic [7:0] addr, input logic [31:0] data);
    bus_if.i_sel   = 1'b1;
    bus_if.i_we    = 1'b1;
    bus_if.i_addr  = addr;
    bus_if.i_wdata = data;
  endtask

  // Called at a negedge; returns at the next negedge after the write is captured
  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    drive_wr(addr, data);
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    bus_if.i_sel  = 1'b1;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = addr;
    #1;
    data = bus_if.o_rdata;
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic        e;

    tbl[0]  = '{1'b0, 8'h00, 32'h0,        32'h0,        "rst_ctrl"};
    tbl[1]  = '{1'b0, 8'h04, 32'h0,        32'h1,        "rst_period"};
    tbl[2]  = '{1'b0, 8'h08, 32'h0,        32'h0,        "rst_status"};
    tbl[3]  = '{1'b0, 8'h0C, 32'h0,        32'h0,        "rst_chcfg"};
    tbl[4]  = '{1'b0, 8'h10, 32'h0,        32'h0,        "rst_duty0"};
    tbl[5]  = '{1'b0, 8'h1C, 32'h0,        32'h0,        "rst_duty3"};
    tbl[6]  = '{1'b1, 8'h04, 32'h0,        32'h0,        "wr_period0"};
    tbl[7]  = '{1'b0, 8'h04, 32'h0,        32'h1,        "period_zero_clamp"};
    tbl[8]  = '{1'b1, 8'h04, 32'hABCD1234, 32'h0,        "wr_period"};
    tbl[9]  = '{1'b0, 8'h04, 32'h0,        32'h1234,     "period_low_bits"};
    tbl[10] = '{1'b1, 8'h0C, 32'hFFFFFFFF, 32'h0,        "wr_chcfg"};
    tbl[11] = '{1'b0, 8'h0C, 32'h0,        32'h000F000F, "chcfg_unused_bits"};
    tbl[12] = '{1'b1, 8'h0C, 32'h0,        32'h0,        "wr_chcfg0"};
    tbl[13] = '{1'b1, 8'h00, 32'hFFFFFFF8, 32'h0,        "wr_ctrl"};
    tbl[14] = '{1'b0, 8'h00, 32'h0,        32'h0,        "ctrl_unused_bits"};
    tbl[15] = '{1'b1, 8'h1C, 32'h5555,     32'h0,        "wr_duty3"};
    tbl[16] = '{1'b0, 8'h1C, 32'h0,        32'h5555,     "duty3_rw"};
    tbl[17] = '{1'b1, 8'h20, 32'h1234,     32'h0,        "wr_unmapped"};
    tbl[18] = '{1'b0, 8'h20, 32'h0,        32'h0,        "unmapped_duty4"};
    tbl[19] = '{1'b0, 8'h1C, 32'h0,        32'h5555,     "duty3_kept"};
    tbl[20] = '{1'b1, 8'h14, 32'h00010000, 32'h0,        "wr_duty1"};
    tbl[21] = '{1'b0, 8'h14, 32'h0,        32'h0,        "duty1_low_bits"};
    tbl[22] = '{1'b0, 8'h44, 32'h0,        32'h0,        "unmapped_44"};
    tbl[23] = '{1'b0, 8'h01, 32'h0,        32'h0,        "unaligned_01"};
    tbl[24] = '{1'b1, 8'h1C, 32'h0,        32'h0,        "wr_duty3_clr"};

    bus_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'h0);
    check("rst_irq", 32'(o_irq), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Register access table, counter idle
    for (int i = 0; i < 25; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else begin
        rd(tbl[i].addr, r);
        check(tbl[i].name, r, tbl[i].exp);
      end
    end
    #1;
    check("rdata_idle", bus_if.o_rdata, 32'h0);
    drive_wr(8'h04, 32'h7);
    #1;
    check("rdata_on_write", bus_if.o_rdata, 32'h0);
    @(negedge clk);
    bus_idle();

    // Edge mode P=10 D0=3
    wr(8'h0C, 32'h1);
    wr(8'h04, 32'd10);
    wr(8'h10, 32'd3);
    wr(8'h00, 32'h1);
    for (int k = 0; k < 22; k++) begin
      e = (k == 0) ? 1'b0 : (((k - 1) % 10) < 3);
      check($sformatf("edge_d3_k%0d", k), 32'(pwm_out[0]), 32'(e));
      @(negedge clk);
    end

    // Shadow duty write mid-period
    wr(8'h00, 32'h0);
    wr(8'h00, 32'h1);
    for (int k = 0; k < 25; k++) begin
      if (k == 0)       e = 1'b0;
      else if (k <= 10) e = ((k - 1) < 3);
      else              e = (((k - 11) % 10) < 7);
      check($sformatf("shadow_k%0d", k), 32'(pwm_out[0]), 32'(e));
      if (k == 4) drive_wr(8'h10, 32'd7);
      @(negedge clk);
      bus_idle();
    end

    // Center mode P=4 D0=1, then inverted polarity
    wr(8'h00, 32'h0);
    wr(8'h04, 32'd4);
    wr(8'h10, 32'd1);
    wr(8'h00, 32'h3);
    for (int k = 0; k < 18; k++) begin
      e = (k == 0) ? 1'b0 : ((((k - 1) % 8) == 0) || (((k - 1) % 8) == 7));
      check($sformatf("center_k%0d", k), 32'(pwm_out[0]), 32'(e));
      @(negedge clk);
    end
    wr(8'h0C, 32'h00010001);
    wr(8'h00, 32'h0);
    wr(8'h00, 32'h3);
    for (int k = 0; k < 18; k++) begin
      e = (k == 0) ? 1'b1 : !((((k - 1) % 8) == 0) || (((k - 1) % 8) == 7));
      check($sformatf("center_pol_k%0d", k), 32'(pwm_out[0]), 32'(e));
      @(negedge clk);
    end

    // Clamps: D1 over period, D2 zero, ch3 disabled
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'h7);
    wr(8'h04, 32'd10);
    wr(8'h14, 32'd15);
    wr(8'h18, 32'd0);
    wr(8'h10, 32'd3);
    wr(8'h00, 32'h1);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("clamp_k%0d", k), 32'(pwm_out[3:1]), (k == 0) ? 32'h0 : 32'h1);
      @(negedge clk);
    end

    // Interrupt and W1C racing a boundary
    wr(8'h00, 32'h0);
    wr(8'h0C, 32'h1);
    wr(8'h04, 32'd4);
    wr(8'h08, 32'h2);
    rd(8'h08, r);
    check("pef_cleared", r & 32'h2, 32'h0);
    wr(8'h00, 32'h5);
    for (int k = 0; k < 10; k++) begin
      e = (k >= 4) && (k <= 8);
      check($sformatf("irq_k%0d", k), 32'(o_irq), 32'(e));
      if (k == 7 || k == 8) drive_wr(8'h08, 32'h2);
      @(negedge clk);
      bus_idle();
    end
    rd(8'h08, r);
    check("status_running", r & 32'h1, 32'h1);

    // Asynchronous reset mid-run
    wr(8'h0C, 32'h000F0000);
    repeat (5) @(negedge clk);
    check("pre_rst_pwm", 32'(pwm_out), 32'hF);
    check("pre_rst_irq", 32'(o_irq), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'h0);
    check("async_rst_irq", 32'(o_irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(8'h04, r);
    check("post_rst_period", r, 32'h1);
    rd(8'h00, r);
    check("post_rst_ctrl", r, 32'h0);
    rd(8'h08, r);
    check("post_rst_status", r, 32'h0);
    repeat (3) @(negedge clk);
    check("post_rst_idle_pwm", 32'(pwm_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
